// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for seq_alu.
//   OP_W            opcode width
//   OP_ADD..OP_MUL  fixed opcode encoding
//   state_t         control FSM states; BUSY exists only with ALU_MUL_EN
package alu_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_ADC = 3'd2;
  localparam logic [OP_W-1:0] OP_SBC = 3'd3;
  localparam logic [OP_W-1:0] OP_AND = 3'd4;
  localparam logic [OP_W-1:0] OP_OR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR = 3'd6;
  localparam logic [OP_W-1:0] OP_MUL = 3'd7;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif
endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: valid/ready request + response bundle for seq_alu.
//   request : in_valid, in_ready, op, a, b
//   response: out_valid, out_ready, res, co, zf, nf, vf
//   master = requester/consumer side, slave = ALU side.
interface seq_alu_if
  import alu_pkg::*;
#(
  parameter int N = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    res;
  logic            co;
  logic            zf;
  logic            nf;
  logic            vf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, co, zf, nf, vf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, co, zf, nf, vf
  );
endinterface

// File: rtl/alu_adder.sv
// alu_adder: N-bit combinational adder with carry in/out.
//   i_a, i_b : operands      i_cin  : carry in
//   o_sum    : N-bit sum     o_cout : carry out
module alu_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered N-bit ALU with valid/ready handshakes and a stored
// carry C for multi-word ADC/SBC chains.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_alu_if.slave (op/a/b request, res/co/zf/nf/vf response)
// Optional macro ALU_MUL_EN adds an N-cycle shift-add unsigned MUL (op 7);
// without it op 7 passes A through in a single cycle.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_alu_if.slave   bus
);
  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_res;
  logic         r_co, r_zf, r_nf, r_vf, r_c;

  logic [N-1:0] w_add_a, w_add_b, w_sum;
  logic         w_add_ci, w_cout;
  logic [N-1:0] w_res;
  logic         w_co, w_vf, w_arith, w_accept;

`ifdef ALU_MUL_EN
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  logic [N-1:0]  r_acc, r_mplr, r_mcand;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  w_acc_nxt, w_mplr_nxt;
  logic          w_last;

  // {acc, mplr} is the 2N-bit partial product, shifted right once per step;
  // mplr[0] is the multiplier bit being consumed.
  assign w_acc_nxt  = {w_cout, w_sum[N-1:1]};
  assign w_mplr_nxt = {w_sum[0], r_mplr[N-1:1]};
  assign w_last     = (r_cnt == CW'(N - 1));
`endif

  assign w_accept      = bus.in_valid && (r_state == IDLE);
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.res       = r_res;
  assign bus.co        = r_co;
  assign bus.zf        = r_zf;
  assign bus.nf        = r_nf;
  assign bus.vf        = r_vf;

  // Adder operand muxing: request operands in IDLE, accumulate step in BUSY.
  always_comb begin
    w_add_a  = bus.a;
    w_add_b  = bus.b;
    w_add_ci = 1'b0;
    case (bus.op)
      OP_SUB:  begin w_add_b = ~bus.b; w_add_ci = 1'b1; end
      OP_ADC:  w_add_ci = r_c;
      OP_SBC:  begin w_add_b = ~bus.b; w_add_ci = r_c; end
      default: ;
    endcase
`ifdef ALU_MUL_EN
    if (r_state == BUSY) begin
      w_add_a  = r_acc;
      w_add_b  = r_mplr[0] ? r_mcand : '0;
      w_add_ci = 1'b0;
    end
`endif
  end

  alu_adder #(.N(N)) u_add (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_cin (w_add_ci),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  // Single-cycle result; w_add_b already holds the possibly inverted B.
  always_comb begin
    w_res   = w_sum;
    w_co    = w_cout;
    w_vf    = (bus.a[N-1] == w_add_b[N-1]) && (w_sum[N-1] != bus.a[N-1]);
    w_arith = 1'b1;
    case (bus.op)
      OP_AND:  begin w_res = bus.a & bus.b; w_co = r_c; w_vf = 1'b0; w_arith = 1'b0; end
      OP_OR:   begin w_res = bus.a | bus.b; w_co = r_c; w_vf = 1'b0; w_arith = 1'b0; end
      OP_XOR:  begin w_res = bus.a ^ bus.b; w_co = r_c; w_vf = 1'b0; w_arith = 1'b0; end
      OP_MUL:  begin w_res = bus.a;         w_co = r_c; w_vf = 1'b0; w_arith = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.in_valid) begin
`ifdef ALU_MUL_EN
        w_state_nxt = (bus.op == OP_MUL) ? BUSY : DONE;
`else
        w_state_nxt = DONE;
`endif
      end
`ifdef ALU_MUL_EN
      BUSY: if (w_last) w_state_nxt = DONE;
`endif
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
      r_co  <= 1'b0;
      r_zf  <= 1'b0;
      r_nf  <= 1'b0;
      r_vf  <= 1'b0;
      r_c   <= 1'b0;
`ifdef ALU_MUL_EN
      r_acc   <= '0;
      r_mplr  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
`endif
    end else begin
`ifdef ALU_MUL_EN
      if (w_accept && bus.op == OP_MUL) begin
        r_acc   <= '0;
        r_mcand <= bus.a;
        r_mplr  <= bus.b;
        r_cnt   <= '0;
      end else
`endif
      if (w_accept) begin
        r_res <= w_res;
        r_co  <= w_co;
        r_vf  <= w_vf;
        r_zf  <= (w_res == '0);
        r_nf  <= w_res[N-1];
        if (w_arith) r_c <= w_co;
      end
`ifdef ALU_MUL_EN
      if (r_state == BUSY) begin
        r_acc  <= w_acc_nxt;
        r_mplr <= w_mplr_nxt;
        r_cnt  <= r_cnt + CW'(1);
        if (w_last) begin
          // High half nonzero means the product does not fit in N bits.
          r_res <= w_mplr_nxt;
          r_co  <= |w_acc_nxt;
          r_vf  <= |w_acc_nxt;
          r_c   <= |w_acc_nxt;
          r_zf  <= (w_mplr_nxt == '0);
          r_nf  <= w_mplr_nxt[N-1];
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed, table-driven bench for seq_alu (N=8), plus
// backpressure and mid-operation reset sequences. Honors ALU_MUL_EN.
module tb_seq_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.N(8)) ifc ();
  seq_alu #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, res;
    logic       co, zf, nf, vf;
    int         lat;
  } vec_t;

  vec_t vecs[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op_i, input logic [7:0] a_i, input logic [7:0] b_i);
    int n = 0;
    @(negedge clk);
    while (!ifc.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("issue_ready", 32'(ifc.in_ready), 32'd1);
    ifc.in_valid = 1'b1; ifc.op = op_i; ifc.a = a_i; ifc.b = b_i;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask

  // Latency = negedges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ifc.out_valid && lat < 40);
  endtask

  task automatic consume();
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("idle_out_valid", 32'(ifc.out_valid), 32'd0);
  endtask

  function automatic vec_t mk(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] res,
                              logic co, logic zf, logic nf, logic vf, int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res;
    v.co = co; v.zf = zf; v.nf = nf; v.vf = vf; v.lat = lat;
    return v;
  endfunction

  initial begin
    int lat;
    logic [7:0] hold_res;
    logic [3:0] hold_fl;

    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    ifc.op = '0; ifc.a = '0; ifc.b = '0;

    // Ordered: stored carry C threads through consecutive vectors.
    vecs.push_back(mk(OP_ADD, 8'd3,   8'd2,   8'h05, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SUB, 8'd3,   8'd2,   8'h01, 1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SUB, 8'd2,   8'd3,   8'hFF, 0, 0, 1, 0, 1));
    vecs.push_back(mk(OP_ADD, 8'h7F,  8'h01,  8'h80, 0, 0, 1, 1, 1));
    vecs.push_back(mk(OP_ADD, 8'hFF,  8'h01,  8'h00, 1, 1, 0, 0, 1)); // C=1
    vecs.push_back(mk(OP_ADC, 8'h00,  8'h00,  8'h01, 0, 0, 0, 0, 1)); // C=0
    vecs.push_back(mk(OP_AND, 8'hF0,  8'h3C,  8'h30, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_OR,  8'hA0,  8'h05,  8'hA5, 0, 0, 1, 0, 1));
    vecs.push_back(mk(OP_XOR, 8'hFF,  8'hFF,  8'h00, 0, 1, 0, 0, 1));
    vecs.push_back(mk(OP_SBC, 8'h05,  8'h03,  8'h01, 1, 0, 0, 0, 1)); // C=1
    vecs.push_back(mk(OP_SBC, 8'h80,  8'h01,  8'h7F, 1, 0, 0, 1, 1)); // C=1
    vecs.push_back(mk(OP_ADC, 8'h7F,  8'h00,  8'h80, 0, 0, 1, 1, 1)); // C=0
    vecs.push_back(mk(OP_ADD, 8'hFF,  8'h02,  8'h01, 1, 0, 0, 0, 1)); // C=1
    vecs.push_back(mk(OP_AND, 8'h0F,  8'hF0,  8'h00, 1, 1, 0, 0, 1)); // co = C
`ifdef ALU_MUL_EN
    vecs.push_back(mk(OP_MUL, 8'd16,  8'd17,  8'h10, 1, 0, 0, 1, 9)); // C=1
    vecs.push_back(mk(OP_MUL, 8'd15,  8'd17,  8'hFF, 0, 0, 1, 0, 9)); // C=0
    vecs.push_back(mk(OP_MUL, 8'd0,   8'hFF,  8'h00, 0, 1, 0, 0, 9));
    vecs.push_back(mk(OP_ADC, 8'h00,  8'h00,  8'h00, 0, 1, 0, 0, 1));
`else
    vecs.push_back(mk(OP_MUL, 8'h42,  8'h99,  8'h42, 1, 0, 0, 0, 1)); // C unchanged
    vecs.push_back(mk(OP_MUL, 8'h80,  8'h01,  8'h80, 1, 0, 1, 0, 1));
    vecs.push_back(mk(OP_ADC, 8'h00,  8'h00,  8'h01, 0, 0, 0, 0, 1));
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_res", 32'(ifc.res), 32'd0);
    chk("rst_flags", 32'({ifc.co, ifc.zf, ifc.nf, ifc.vf}), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_out(lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_res", i), 32'(ifc.res), 32'(vecs[i].res));
      chk($sformatf("v%0d_co", i), 32'(ifc.co), 32'(vecs[i].co));
      chk($sformatf("v%0d_zf", i), 32'(ifc.zf), 32'(vecs[i].zf));
      chk($sformatf("v%0d_nf", i), 32'(ifc.nf), 32'(vecs[i].nf));
      chk($sformatf("v%0d_vf", i), 32'(ifc.vf), 32'(vecs[i].vf));
      consume();
    end

    // Backpressure: hold DONE 5 cycles while a new request is offered.
    issue(OP_ADD, 8'h7F, 8'h01);
    wait_out(lat);
    hold_res = 8'h80; hold_fl = 4'b0011;
    ifc.in_valid = 1'b1; ifc.op = OP_SUB; ifc.a = 8'h11; ifc.b = 8'h22;
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("bp_res", 32'(ifc.res), 32'(hold_res));
      chk("bp_flags", 32'({ifc.co, ifc.zf, ifc.nf, ifc.vf}), 32'(hold_fl));
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
    consume();
    @(negedge clk);
    chk("bp_no_ghost", 32'(ifc.out_valid), 32'd0);

    // Mid-operation reset, with C=1 beforehand so clearing is observable.
    issue(OP_ADD, 8'hFF, 8'h01);
    wait_out(lat);
    consume();
`ifdef ALU_MUL_EN
    issue(OP_MUL, 8'd16, 8'd17);
    repeat (3) @(negedge clk);
`else
    issue(OP_ADD, 8'h01, 8'h01);
    @(negedge clk);
`endif
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("midrst_res", 32'(ifc.res), 32'd0);
    chk("midrst_flags", 32'({ifc.co, ifc.zf, ifc.nf, ifc.vf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (ifc.out_valid) begin
        nerr++;
        $display("FAIL midrst_emit: got out_valid 1, expected 0");
      end
    end
    issue(OP_ADC, 8'd1, 8'd1);
    wait_out(lat);
    chk("postrst_lat", 32'(lat), 32'd1);
    chk("postrst_res", 32'(ifc.res), 32'd2);
    chk("postrst_co", 32'(ifc.co), 32'd0);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
